alu_entry_sequencer: RTL

- Button-driven controller that sequences the lab datapath: switches → mini-ALU → seven-segment display.
- It debounces a push key and walks the user through operand entry.
- It drives the ALU operands and opcode from held registers, waits for the ALU result and captures it.
- It selects what the display shows and when it is blanked. The ALU and the binary-to-seven-segment display module sit outside this block.

---
 rtl/alu_entry_sequencer_if.sv | 24 ++
 rtl/alu_entry_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_entry_sequencer_if.sv
// Signal bundle between the entry sequencer and the lab board: push key, switches,
// the external mini-ALU and the seven-segment display driver.
interface alu_entry_sequencer_if;
  logic        key_n;
  logic [9:0]  switches;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_op;
  logic [19:0] alu_result;
  logic [19:0] disp_value;
  logic        disp_blank;
  logic [1:0]  state;
  logic        busy;

  modport master (
    output key_n, switches, alu_result,
    input  alu_a, alu_b, alu_op, disp_value, disp_blank, state, busy
  );

  modport slave (
    input  key_n, switches, alu_result,
    output alu_a, alu_b, alu_op, disp_value, disp_blank, state, busy
  );
endinterface

// File: rtl/alu_entry_sequencer.sv
// Debounces the push key, steps the user through operand A / operand B entry,
// holds the ALU inputs, captures the ALU result and chooses what the display shows.
module alu_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int ALU_LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_entry_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENTER_B = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] SHOW    = 2'd3;

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int WW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  logic          sync1, sync2;
  logic          deb, deb_prev;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    flush;
  logic          armed;
  logic          press;

  logic [1:0]    state_q;
  logic [3:0]    a_q, b_q;
  logic          op_q;
  logic [19:0]   result_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [WW-1:0] wait_cnt;

  // Presses stay disarmed after reset until the synchronized key has really been
  // seen released, so a key held through reset never yields a phantom press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      deb      <= 1'b1;
      deb_prev <= 1'b1;
      deb_cnt  <= '0;
      flush    <= '0;
      armed    <= 1'b0;
      press    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes the two-stage synchronizer an actual two-stage delay.
      sync1    <= bus.key_n;
      sync2    <= sync1;
      deb_prev <= deb;
      flush    <= {flush[0], 1'b1};
      armed    <= armed | (flush[1] & sync2);
      press    <= armed & deb_prev & ~deb;
      if (sync2 != deb) begin
        if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb     <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      result_q    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            a_q         <= bus.switches[9:6];
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            state_q     <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (press) begin
            b_q      <= bus.switches[5:2];
            op_q     <= bus.switches[1];
            wait_cnt <= '0;
            state_q  <= WAIT;
          end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_phase <= ~blink_phase;
            blink_cnt   <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        WAIT: begin
          // Presses are deliberately ignored here; they are not queued for SHOW.
          if (wait_cnt == WW'(ALU_LATENCY - 1)) begin
            result_q <= bus.alu_result;
            state_q  <= SHOW;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (press) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaulting every output first means no path through the case can
    // leave it unassigned, so no latch is inferred.
    bus.disp_value = result_q;
    case (state_q)
      IDLE:    bus.disp_value = {16'b0, bus.switches[9:6]};
      ENTER_B: bus.disp_value = {16'b0, bus.switches[5:2]};
      default: bus.disp_value = result_q;
    endcase
    bus.disp_blank = ~bus.switches[0] | (state_q == WAIT) |
                     ((state_q == ENTER_B) & blink_phase);
  end

  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_op = op_q;
  assign bus.state  = state_q;
  assign bus.busy   = (state_q == WAIT);

endmodule
